// File: rtl/turtle_io_pkg.sv
// turtle_io_pkg: shared word width, word type and sticky error flags for the IN/OUT port
package turtle_io_pkg;
  localparam int DEF_DATA_W = 16;
  typedef logic [DEF_DATA_W-1:0] word_t;
  typedef struct packed {
    logic out_overflow;
    logic in_underflow;
  } err_t;
endpackage

// File: rtl/turtle_io_port_fifo.sv
// io_fifo: first-word-fall-through FIFO; a push into a full FIFO is accepted when a pop happens
// in the same cycle, and a pop of an empty FIFO is ignored.
module io_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;
  assign empty  = r_count == '0;
  assign full   = r_count == CW'(DEPTH);
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign head   = empty ? '0 : r_mem[r_rd];
  assign count  = r_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  // storage needs no reset: head is masked to zero while empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= push_data;
  end
endmodule

// File: rtl/turtle_io_port.sv
// turtle_io_port: OUT-strobe FIFO drained to an external stream, and an external-stream FIFO read by IN;
// the CPU never stalls, so drops and empty reads raise sticky flags.
module turtle_io_port #(
  parameter int DATA_W    = turtle_io_pkg::DEF_DATA_W,
  parameter int OUT_DEPTH = 4,
  parameter int IN_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_out_valid,
  input  logic [DATA_W-1:0] cpu_out_data,
  input  logic              cpu_in_read,
  output logic [DATA_W-1:0] cpu_in_data,
  output logic              out_full,
  output logic              in_empty,
  output logic              ext_out_valid,
  input  logic              ext_out_ready,
  output logic [DATA_W-1:0] ext_out_data,
  input  logic              ext_in_valid,
  output logic              ext_in_ready,
  input  logic [DATA_W-1:0] ext_in_data,
  output logic              out_overflow,
  output logic              in_underflow,
  input  logic              err_clr
);
  import turtle_io_pkg::*;
  logic [$clog2(OUT_DEPTH+1)-1:0] w_out_count;
  logic [$clog2(IN_DEPTH+1)-1:0]  w_in_count;
  logic w_out_full, w_out_empty, w_out_pop;
  logic w_in_full, w_in_empty;
  logic w_ovf_set, w_unf_set;
  err_t r_err;
  assign w_out_pop     = !w_out_empty && ext_out_ready;
  assign ext_out_valid = !w_out_empty;
  assign out_full      = w_out_count == ($bits(w_out_count))'(OUT_DEPTH);
  assign in_empty      = w_in_count == '0;
  // ready depends only on the registered count, never on this cycle's IN read
  assign ext_in_ready  = !w_in_full;
  assign w_ovf_set     = cpu_out_valid && w_out_full && !w_out_pop;
  assign w_unf_set     = cpu_in_read && w_in_empty;
  assign out_overflow  = r_err.out_overflow;
  assign in_underflow  = r_err.in_underflow;
  io_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cpu_out_valid),
    .push_data (cpu_out_data),
    .pop       (w_out_pop),
    .head      (ext_out_data),
    .count     (w_out_count),
    .full      (w_out_full),
    .empty     (w_out_empty)
  );
  io_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ext_in_valid && ext_in_ready),
    .push_data (ext_in_data),
    .pop       (cpu_in_read),
    .head      (cpu_in_data),
    .count     (w_in_count),
    .full      (w_in_full),
    .empty     (w_in_empty)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= '0;
    end else begin
      r_err.out_overflow <= w_ovf_set || (r_err.out_overflow && !err_clr);
      r_err.in_underflow <= w_unf_set || (r_err.in_underflow && !err_clr);
    end
  end
endmodule

// File: tb/tb_turtle_io_port.sv
// tb_turtle_io_port: directed test-plan sequences plus random traffic, checked by a queue-based monitor
module tb_turtle_io_port;
  import turtle_io_pkg::*;
  localparam int OD = 4;
  localparam int ID = 4;
  logic clk = 0, rst = 1;
  logic cpu_out_valid = 0, cpu_in_read = 0, ext_out_ready = 0, ext_in_valid = 0, err_clr = 0;
  word_t cpu_out_data = '0, ext_in_data = '0;
  word_t cpu_in_data, ext_out_data;
  logic out_full, in_empty, ext_out_valid, ext_in_ready, out_overflow, in_underflow;
  int cmp = 0, errs = 0;
  word_t out_q[$];
  word_t in_q[$];
  bit m_ovf = 0, m_unf = 0;
  int on, inn;
  bit opop, irdy, ovf_set, unf_set;

  turtle_io_port #(.DATA_W(16), .OUT_DEPTH(OD), .IN_DEPTH(ID)) dut (
    .clk(clk), .rst(rst), .cpu_out_valid(cpu_out_valid), .cpu_out_data(cpu_out_data),
    .cpu_in_read(cpu_in_read), .cpu_in_data(cpu_in_data), .out_full(out_full), .in_empty(in_empty),
    .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready), .ext_out_data(ext_out_data),
    .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready), .ext_in_data(ext_in_data),
    .out_overflow(out_overflow), .in_underflow(in_underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs with the queue model, then advances the model to the next edge.
  always @(negedge clk) begin
    if (rst) begin
      out_q.delete();
      in_q.delete();
      m_ovf = 0;
      m_unf = 0;
      chk("rst_out_valid", ext_out_valid, 0);
      chk("rst_out_data", ext_out_data, 0);
      chk("rst_in_data", cpu_in_data, 0);
      chk("rst_out_full", out_full, 0);
      chk("rst_in_empty", in_empty, 1);
      chk("rst_in_ready", ext_in_ready, 1);
      chk("rst_flags", {out_overflow, in_underflow}, 0);
    end else begin
      on = out_q.size();
      inn = in_q.size();
      opop = on != 0 && ext_out_ready;
      irdy = inn < ID;
      chk("out_valid", ext_out_valid, on != 0);
      chk("out_data", ext_out_data, on != 0 ? out_q[0] : 16'h0);
      chk("out_full", out_full, on == OD);
      chk("in_empty", in_empty, inn == 0);
      chk("in_ready", ext_in_ready, irdy);
      chk("in_data", cpu_in_data, inn != 0 ? in_q[0] : 16'h0);
      chk("out_overflow", out_overflow, m_ovf);
      chk("in_underflow", in_underflow, m_unf);
      if (opop) void'(out_q.pop_front());
      ovf_set = cpu_out_valid && on == OD && !opop;
      if (cpu_out_valid && !ovf_set) out_q.push_back(cpu_out_data);
      unf_set = cpu_in_read && inn == 0;
      if (cpu_in_read && inn != 0) void'(in_q.pop_front());
      if (ext_in_valid && irdy) in_q.push_back(ext_in_data);
      m_ovf = ovf_set || (m_ovf && !err_clr);
      m_unf = unf_set || (m_unf && !err_clr);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    cpu_out_valid = 0;
    cpu_in_read = 0;
    ext_in_valid = 0;
    err_clr = 0;
  endtask

  task automatic strobe(input word_t d);
    cpu_out_valid = 1;
    cpu_out_data = d;
    cyc();
    cpu_out_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(3);
    rst = 0;
    cyc(2);
    // output drain
    ext_out_ready = 1;
    strobe(16'h1234);
    strobe(16'hABCD);
    strobe(16'h0001);
    cyc(3);
    // output overflow
    ext_out_ready = 0;
    for (int i = 0; i < 5; i++) strobe(16'h0010 + 16'(i));
    chk("ovf_flag_direct", out_overflow, 1);
    chk("ovf_full_direct", out_full, 1);
    ext_out_ready = 1;
    cyc(6);
    err_clr = 1;
    cyc();
    err_clr = 0;
    chk("ovf_cleared", out_overflow, 0);
    // full with simultaneous pop
    ext_out_ready = 0;
    for (int i = 0; i < 4; i++) strobe(16'h0020 + 16'(i));
    ext_out_ready = 1;
    strobe(16'h00FF);
    ext_out_ready = 0;
    chk("fullpop_no_ovf", out_overflow, 0);
    chk("fullpop_full", out_full, 1);
    ext_out_ready = 1;
    cyc(6);
    // input path
    ext_in_valid = 1;
    ext_in_data = 16'h5555;
    cyc();
    ext_in_data = 16'h6666;
    cyc();
    ext_in_valid = 0;
    chk("in_first", cpu_in_data, 16'h5555);
    cpu_in_read = 1;
    cyc(2);
    cpu_in_read = 0;
    chk("in_empty_after", in_empty, 1);
    // back-pressure, then underflow and clear
    ext_in_valid = 1;
    for (int i = 0; i < 6; i++) begin
      ext_in_data = 16'h0100 + 16'(i);
      cyc();
    end
    ext_in_valid = 0;
    chk("bp_ready_low", ext_in_ready, 0);
    cpu_in_read = 1;
    cyc(5);
    cpu_in_read = 0;
    chk("unf_flag", in_underflow, 1);
    err_clr = 1;
    cyc();
    err_clr = 0;
    chk("unf_cleared", in_underflow, 0);
    // async reset with traffic in both FIFOs and a flag set
    cpu_in_read = 1;
    cyc();
    cpu_in_read = 0;
    ext_out_ready = 0;
    ext_in_valid = 1;
    ext_in_data = 16'h0A0A;
    strobe(16'h0B0B);
    ext_in_data = 16'h0C0C;
    strobe(16'h0D0D);
    idle();
    chk("pre_rst_valid", ext_out_valid, 1);
    chk("pre_rst_unf", in_underflow, 1);
    #2 rst = 1;
    #1;
    chk("arst_out_valid", ext_out_valid, 0);
    chk("arst_in_empty", in_empty, 1);
    chk("arst_in_ready", ext_in_ready, 1);
    chk("arst_flags", {out_overflow, in_underflow}, 0);
    cyc(2);
    rst = 0;
    cyc();
    // random traffic
    for (int i = 0; i < 2000; i++) begin
      cpu_out_valid = $urandom_range(1, 0) == 1;
      cpu_out_data = 16'($urandom);
      ext_out_ready = $urandom_range(9, 0) < 6;
      ext_in_valid = $urandom_range(1, 0) == 1;
      ext_in_data = 16'($urandom);
      cpu_in_read = $urandom_range(9, 0) < 4;
      err_clr = $urandom_range(19, 0) == 0;
      cyc();
    end
    idle();
    cyc(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
